// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the programmable clock divider.
//   DEFAULT_DIV_25M_64K : reset period (25 MHz input -> ~64 kHz output)
//   half_ceil(p)        : ceil(p/2), the number of low cycles in a period
//   div_valid(p)        : true when p is a usable period (p >= 2)
// Helpers take 32-bit operands so they serve any counter width up to 32.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int unsigned DEFAULT_DIV_25M_64K = 390;

  function automatic logic [31:0] half_ceil(input logic [31:0] p);
    return (p >> 1) + {31'd0, p[0]};
  endfunction

  function automatic logic div_valid(input logic [31:0] p);
    return p >= 32'd2;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel: period counter, active/shadow period, pending flag and
// registered outputs.
//   clk_in     : clock
//   reset_n    : asynchronous active-low reset
//   en         : run enable (0 forces phase 0 and lands any pending period)
//   sync_start : restart at phase 0 (when enabled)
//   wr         : write strobe for this channel
//   wr_div     : new period written into the shadow register
//   clk_out    : divided waveform, high when count >= ceil(P/2)
//   tick       : one-cycle strobe on the last cycle of each period
//   pending    : a shadow period waits for the next period boundary
// -----------------------------------------------------------------------------
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_25M_64K
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync_start,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] p_act, p_act_nx;
  logic [CNT_W-1:0] p_shadow, p_shadow_nx;
  logic             pending_nx;
  logic             boundary;
  logic             clk_out_nx;
  logic             tick_nx;
  logic             act_ok_nx;

  always_comb begin
    count_nx = count;
    boundary = 1'b0;
    if (!en) begin
      count_nx = '0;
      boundary = 1'b1;
    end else if (sync_start) begin
      count_nx = '0;
      boundary = 1'b1;
    end else if (!div_valid(32'(p_act))) begin
      // Unusable period: park at phase 0; only disable/sync can load a new one.
      count_nx = '0;
    end else if (count == p_act - ONE) begin
      count_nx = '0;
      boundary = 1'b1;
    end else begin
      count_nx = count + ONE;
    end
  end

  // A write on a boundary edge keeps the new value pending: the boundary
  // consumes the shadow value that was already there.
  always_comb begin
    p_act_nx    = (boundary && pending) ? p_shadow : p_act;
    p_shadow_nx = wr ? wr_div : p_shadow;
    pending_nx  = wr ? 1'b1 : (boundary ? 1'b0 : pending);
  end

  // Outputs are decoded from next-state count/period and registered.
  always_comb begin
    act_ok_nx  = div_valid(32'(p_act_nx));
    clk_out_nx = act_ok_nx && (32'(count_nx) >= half_ceil(32'(p_act_nx)));
    tick_nx    = act_ok_nx && (count_nx == p_act_nx - ONE);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      p_act    <= DIV_RST;
      p_shadow <= DIV_RST;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      count    <= count_nx;
      p_act    <= p_act_nx;
      p_shadow <= p_shadow_nx;
      pending  <= pending_nx;
      clk_out  <= clk_out_nx;
      tick     <= tick_nx;
    end
  end

endmodule

// File: rtl/prog_clk_divider.sv
// -----------------------------------------------------------------------------
// prog_clk_divider
// Multi-channel runtime-programmable clock divider. Each channel produces a
// registered divided waveform and a period tick; ratio updates land only at
// period boundaries.
//   clk_in      : sole clock
//   reset_n     : asynchronous active-low reset
//   cfg_wr      : one-cycle write strobe for a divide value
//   cfg_ch      : target channel of cfg_wr (out-of-range values ignored)
//   cfg_div     : new period in clk_in cycles
//   sync_start  : restart all enabled channels at phase 0
//   ch_en       : per-channel run enable
//   clk_out     : per-channel divided waveform
//   tick        : per-channel last-cycle-of-period strobe
//   cfg_pending : per-channel "written value awaiting boundary"
// -----------------------------------------------------------------------------
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 16,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_25M_64K,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              sync_start,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [NUM_CH-1:0] ch_wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Exact match decode: channel numbers >= NUM_CH select nothing.
    assign ch_wr[i] = cfg_wr && (32'(cfg_ch) == 32'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .en         (ch_en[i]),
      .sync_start (sync_start),
      .wr         (ch_wr[i]),
      .wr_div     (cfg_div),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .pending    (cfg_pending[i])
    );
  end

endmodule

// File: doc/prog_clk_divider.md
# prog_clk_divider

Multi-channel, runtime-programmable clock divider. It generates NUM_CH independent divided clock-enable waveforms from one clk_in, together with single-cycle tick strobes. Each channel has its own divide ratio, enable, and glitch-free ratio update at period boundaries. It is the general-purpose replacement for the fixed-ratio, single-output divider. It sits beside the system clock source and feeds sample-rate, baud and LED-refresh timing.

## Interface
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 16: counter/divide-value width in bits.
- DEFAULT_DIV, 390: period in clk_in cycles loaded into every channel at reset (25 MHz/64 kHz).
- clk_in  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cfg_wr  input  1  one-cycle write strobe for a divide value.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel of cfg_wr.
- cfg_div  input  CNT_W  new period P in clk_in cycles.
- sync_start  input  1  restart all enabled channels at phase 0.
- ch_en  input  NUM_CH  per-channel run enable.
- clk_out  output  NUM_CH  registered divided waveform per channel.
- tick  output  NUM_CH  registered one-cycle strobe, last cycle of each period.
- cfg_pending  output  NUM_CH  a written value waits for the next period boundary.

## Operation
- Each channel has count (CNT_W), active period P_act, shadow period P_sh, and pending flag.
- Reset (async, reset_n=0): count=0, P_act=P_sh=DEFAULT_DIV, pending=0, clk_out=0, tick=0, cfg_pending=0.
- P valid range is 2..2^CNT_W-1. With P_act of 0 or 1, the channel holds count=0, clk_out=0, tick=0.
- Running channel: count steps 0,1,…,P_act-1,0.
- clk_out is high exactly when count >= ceil(P_act/2). The low phase is ceil(P/2) cycles, the high phase floor(P/2) cycles.
- tick is high exactly when count == P_act-1.
- Outputs are registers driven from the next-state count, so they never glitch.
- Priority per channel, per edge: reset > ch_en=0 > sync_start > wrap > increment.
- ch_en=0: next edge gives count=0, clk_out=0, tick=0. If pending, P_act<=P_sh and pending clears immediately.
- sync_start=1 with ch_en=1: count<=0 and clk_out/tick<=0. Any pending value is loaded.
- Wrap (count==P_act-1): count<=0. If pending, P_act<=P_sh and pending<=0.
- cfg_wr with cfg_ch<NUM_CH: P_sh<=cfg_div and pending<=1. A later write before the boundary overwrites P_sh.
- cfg_wr with cfg_ch>=NUM_CH is ignored.
- cfg_wr on the same edge as a wrap: the wrap consumes the old P_sh. The new value stays pending until the following wrap.
- The first edge sampling ch_en=1 moves count 0→1. The first tick is therefore registered P_act-1 edges after enable.

## Timing
- cfg_wr to cfg_pending high: 1 cycle.
- Ratio change takes effect on the first period starting after the write. No runt or stretched pulse is produced.
- sync_start to all enabled channels at count 0 with clk_out=0: 1 cycle. Channels with equal P then stay phase-aligned.
- tick coincides with the final high cycle of clk_out.
- P=2 gives clk_out alternating 0,1, with tick on every high cycle.

## Structure
- Package clk_div_pkg holds:
  - DEFAULT_DIV_25M_64K = 390;
  - function half_ceil(P) returning ceil(P/2);
  - function div_valid(P) returning P>=2.
- Sub-module clk_div_channel holds one channel's count, P_act, P_sh, pending and output registers. The top instantiates it NUM_CH times in a generate loop, with decoding of cfg_wr/cfg_ch and fan-out of sync_start.
- The top contains no other sequential logic.

## Test plan
- Reset release, ch_en=4'b0001, P=390 -> ch0 clk_out low 195 / high 195 cycles. tick every 390 cycles; others stay 0.
- Write P=5 to ch1 while enabled -> cfg_pending[1]=1 until the next wrap. After that: low 3, high 2, tick period 5. No period of any other length is observed.
- Write P=1 and P=0 to ch2 -> ch2 clk_out/tick stuck 0. Restoring P=4 (with ch_en toggle) resumes 2/2.
- Two writes to ch3 (P=7 then P=9) within one period, second coincident with wrap -> first period after wrap uses 7. The next uses 9.
- ch0 P=6, ch1 P=6 enabled at different times, then sync_start -> both clk_out and tick identical thereafter.
- Assert reset_n low mid-period -> all outputs 0 asynchronously. After release, P_act=DEFAULT_DIV and cfg_pending=0.
